// File: rtl/hp_divider_seq.sv
// Sequential FP16 divider: op = A / B using a 12-step radix-2 restoring mantissa divider.
// Fixed latency; exception encoding matches hp_multiplier (00 ok, 01 ovf, 10 unf, 11 div-by-zero).
module hp_divider_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [15:0] op,
   output logic [1:0]  exceptions,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_NORM = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        sign;
   logic [4:0]  exp_a;
   logic [4:0]  exp_b;
   logic [10:0] man_b;
   logic [11:0] rem;
   logic [11:0] quo;

   // restoring step
   logic [11:0] divisor;
   logic [11:0] rem_diff;
   logic        ge;
   logic [11:0] rem_next;
   logic [11:0] quo_next;

   always_comb begin
      divisor  = {1'b0, man_b};
      ge       = (rem >= divisor);
      rem_diff = rem - divisor;
      // remainder stays below 2*divisor, so bit 11 is always clear before the shift
      rem_next = ge ? {rem_diff[10:0], 1'b0} : {rem[10:0], 1'b0};
      quo_next = {quo[10:0], ge};
   end

   // normalization and result selection
   logic signed [6:0] exp_base;
   logic signed [6:0] exp_res;
   logic [9:0]        frac;
   logic [15:0]       res_op;
   logic [1:0]        res_exc;

   always_comb begin
      exp_base = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 7'sd15;
      exp_res  = quo[11] ? exp_base : exp_base - 7'sd1;
      frac     = quo[11] ? quo[10:1] : quo[9:0];
      res_op   = {sign, 15'h0000};
      res_exc  = 2'b00;
      if (exp_b == 5'd0) begin
         res_op  = {sign, 5'h1F, 10'h000};
         res_exc = 2'b11;
      end else if (exp_a == 5'd0) begin
         res_op  = {sign, 15'h0000};
         res_exc = 2'b00;
      end else if (exp_res > 7'sd30) begin
         res_op  = {sign, 5'h1F, 10'h000};
         res_exc = 2'b01;
      end else if (exp_res < 7'sd1) begin
         res_op  = {sign, 15'h0000};
         res_exc = 2'b10;
      end else begin
         res_op  = {sign, exp_res[4:0], frac};
         res_exc = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         sign       <= 1'b0;
         exp_a      <= 5'd0;
         exp_b      <= 5'd0;
         man_b      <= 11'd0;
         rem        <= 12'd0;
         quo        <= 12'd0;
         op         <= 16'h0000;
         exceptions <= 2'b00;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  sign  <= A[15] ^ B[15];
                  exp_a <= A[14:10];
                  exp_b <= B[14:10];
                  man_b <= {1'b1, B[9:0]};
                  rem   <= {1'b0, 1'b1, A[9:0]};
                  quo   <= 12'd0;
                  cnt   <= 4'd11;
                  busy  <= 1'b1;
                  state <= S_DIV;
               end
            end
            S_DIV: begin
               rem <= rem_next;
               quo <= quo_next;
               if (cnt == 4'd0) begin
                  state <= S_NORM;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_NORM: begin
               op         <= res_op;
               exceptions <= res_exc;
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
